// File: rtl/sigmoid_pkg.sv
// ============================================================================
// Module   : sigmoid_pkg
// Purpose  : Shared widths, constants and x-to-table-index scaling for the
//            sigmoid activation scheduler.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package sigmoid_pkg;

  localparam int             X_W     = 16;
  localparam int             Y_W     = 8;
  localparam int             IDX_W   = 7;
  localparam int             IDX_MAX = 60;
  localparam logic [Y_W-1:0] Y_HALF  = 8'h80;
  localparam logic [Y_W:0]   Y_ONE   = 9'd256;

  // |x| in Q8.8 maps to a 0.1-step table index, rounded to nearest and clamped.
  function automatic logic [IDX_W-1:0] abs_to_idx(input logic [X_W-1:0] x);
    logic [X_W-1:0] a;
    logic [19:0]    p;
    a = x[X_W-1] ? (~x + X_W'(1)) : x;
    p = ({4'd0, a} * 20'd10 + 20'd128) >> 8;
    if (p > 20'(IDX_MAX)) begin
      return IDX_W'(IDX_MAX);
    end
    return p[IDX_W-1:0];
  endfunction

endpackage

`default_nettype wire

// File: rtl/sigmoid_lut.sv
// ============================================================================
// Module   : sigmoid_lut
// Purpose  : Combinational sigmoid table for x = 0.0 .. 6.0 in 0.1 steps.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sigmoid_lut
  import sigmoid_pkg::*;
(
  input  logic [IDX_W-1:0] addr,
  output logic [15:0]      data
);

  // round(256*sigmoid(i/10)), with 256 capped to 0xFF
  localparam logic [7:0] c_tab [0:IDX_MAX] = '{
    Y_HALF, 8'h86, 8'h8D, 8'h93, 8'h99, 8'h9F, 8'hA5, 8'hAB, 8'hB1, 8'hB6,
    8'hBB,  8'hC0, 8'hC5, 8'hC9, 8'hCD, 8'hD1, 8'hD5, 8'hD8, 8'hDC, 8'hDF,
    8'hE1,  8'hE4, 8'hE6, 8'hE9, 8'hEB, 8'hED, 8'hEE, 8'hF0, 8'hF1, 8'hF3,
    8'hF4,  8'hF5, 8'hF6, 8'hF7, 8'hF8, 8'hF8, 8'hF9, 8'hFA, 8'hFA, 8'hFB,
    8'hFB,  8'hFC, 8'hFC, 8'hFD, 8'hFD, 8'hFD, 8'hFD, 8'hFE, 8'hFE, 8'hFE,
    8'hFE,  8'hFE, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF,
    8'hFF
  };

  always_comb begin
    data = 16'h00FF;
    if (addr <= IDX_W'(IDX_MAX)) begin
      data = {8'h00, c_tab[addr]};
    end
  end

endmodule

`default_nettype wire

// File: rtl/sigmoid_act_sched.sv
// ============================================================================
// Module   : sigmoid_act_sched
// Purpose  : Round-robin sharing of one sigmoid table among NUM_REQ requesters,
//            3-stage pipeline, signed input via sigmoid(-x) = 1 - sigmoid(x).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sigmoid_act_sched #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ),
  parameter int IDX_MAX = 60
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_REQ-1:0]    req_valid,
  input  logic [NUM_REQ*16-1:0] req_x,
  output logic [NUM_REQ-1:0]    req_ready,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [ID_W-1:0]       resp_id,
  output logic [7:0]            resp_y,
  output logic                  busy
);

  import sigmoid_pkg::*;

  logic                 w_adv;
  logic                 w_xfer;
  logic [NUM_REQ-1:0]   w_grant;
  logic [ID_W-1:0]      w_gnt_id;
  logic [ID_W-1:0]      w_cand;
  logic [X_W-1:0]       w_sel_x;
  logic [IDX_W-1:0]     w_idx_raw;
  logic [IDX_W-1:0]     w_s1_idx;
  logic [15:0]          w_lut_data;
  logic [Y_W:0]         w_neg;
  logic [Y_W-1:0]       w_y;
  logic                 w_unused;

  logic [ID_W-1:0]      r_ptr;
  logic                 r_s1_v;
  logic [X_W-1:0]       r_s1_x;
  logic [ID_W-1:0]      r_s1_id;
  logic                 r_s2_v;
  logic                 r_s2_sign;
  logic [IDX_W-1:0]     r_s2_idx;
  logic [ID_W-1:0]      r_s2_id;

  assign w_adv = ~resp_valid | resp_ready;

  // First valid requester at or after the pointer; nothing is granted while stalled.
  always_comb begin
    w_grant  = '0;
    w_gnt_id = '0;
    w_xfer   = 1'b0;
    w_cand   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      w_cand = ID_W'((int'(r_ptr) + k) % NUM_REQ);
      if (!w_xfer && w_adv && req_valid[w_cand]) begin
        w_xfer           = 1'b1;
        w_gnt_id         = w_cand;
        w_grant[w_cand]  = 1'b1;
      end
    end
  end

  assign req_ready = w_grant;
  assign w_sel_x   = req_x[16*w_gnt_id +: X_W];

  assign w_idx_raw = abs_to_idx(r_s1_x);
  assign w_s1_idx  = (int'(w_idx_raw) > IDX_MAX) ? IDX_W'(IDX_MAX) : w_idx_raw;

  sigmoid_lut u_lut (
    .addr (r_s2_idx),
    .data (w_lut_data)
  );

  // Table entries are >= 0x80, so the mirrored value always fits in 8 bits.
  assign w_neg    = Y_ONE - {1'b0, w_lut_data[Y_W-1:0]};
  assign w_y      = r_s2_sign ? w_neg[Y_W-1:0] : w_lut_data[Y_W-1:0];
  assign w_unused = &{1'b0, w_lut_data[15:Y_W], w_neg[Y_W]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ptr      <= '0;
      r_s1_v     <= 1'b0;
      r_s1_x     <= '0;
      r_s1_id    <= '0;
      r_s2_v     <= 1'b0;
      r_s2_sign  <= 1'b0;
      r_s2_idx   <= '0;
      r_s2_id    <= '0;
      resp_valid <= 1'b0;
      resp_id    <= '0;
      resp_y     <= '0;
    end else if (w_adv) begin
      if (w_xfer) begin
        r_ptr <= (w_gnt_id == ID_W'(NUM_REQ-1)) ? '0 : w_gnt_id + ID_W'(1);
      end
      r_s1_v     <= w_xfer;
      r_s1_x     <= w_sel_x;
      r_s1_id    <= w_gnt_id;
      r_s2_v     <= r_s1_v;
      r_s2_sign  <= r_s1_x[X_W-1];
      r_s2_idx   <= w_s1_idx;
      r_s2_id    <= r_s1_id;
      resp_valid <= r_s2_v;
      resp_id    <= r_s2_id;
      resp_y     <= w_y;
    end
  end

  assign busy = r_s1_v | r_s2_v | resp_valid;

endmodule

`default_nettype wire

// File: tb/tb_sigmoid_act_sched.sv
// ============================================================================
// Module   : tb_sigmoid_act_sched
// Purpose  : Directed self-checking bench for sigmoid_act_sched.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_sigmoid_act_sched;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req_valid;
  logic [63:0] req_x;
  logic [3:0]  req_ready;
  logic        resp_valid;
  logic        resp_ready;
  logic [1:0]  resp_id;
  logic [7:0]  resp_y;
  logic        busy;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  sigmoid_act_sched dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_x      (req_x),
    .req_ready  (req_ready),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_id    (resp_id),
    .resp_y     (resp_y),
    .busy       (busy)
  );

  task automatic test_reset();
    rst        = 1'b1;
    req_valid  = 4'b0000;
    req_x      = '0;
    resp_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    total++;
    if ({resp_valid, busy, resp_id, resp_y, req_ready} !== 16'h0000) begin
      bad++;
      $display("FAIL reset_state: got v=%b busy=%b id=%0d y=%h rdy=%b want all zero",
               resp_valid, busy, resp_id, resp_y, req_ready);
    end
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // One isolated request; checks grant, exact 3-cycle latency and result.
  task automatic do_single(input int slot, input logic [15:0] x,
                           input logic [7:0] exp_y, input string name);
    logic [3:0] onehot;
    onehot    = 4'b0001 << slot;
    req_x     = '0;
    req_x[16*slot +: 16] = x;
    req_valid = onehot;
    @(negedge clk);
    total++;
    if (req_ready !== onehot) begin
      bad++;
      $display("FAIL %s_grant: got %b want %b", name, req_ready, onehot);
    end
    @(posedge clk);
    #1 req_valid = 4'b0000;
    @(posedge clk);
    @(negedge clk);
    total++;
    if (resp_valid !== 1'b0) begin
      bad++;
      $display("FAIL %s_early: got resp_valid=%b want 0", name, resp_valid);
    end
    @(posedge clk);
    @(negedge clk);
    total++;
    if ({resp_valid, resp_id, resp_y} !== {1'b1, 2'(slot), exp_y}) begin
      bad++;
      $display("FAIL %s_result: got v=%b id=%0d y=%h want v=1 id=%0d y=%h",
               name, resp_valid, resp_id, resp_y, slot, exp_y);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_basic();
    do_single(0, 16'h0000, 8'h80, "zero");
  endtask

  task automatic test_sign();
    do_single(1, 16'h0100, 8'hBB, "pos_one");
    do_single(2, 16'hFF00, 8'h45, "neg_one");
    do_single(3, 16'h0080, 8'h9F, "pos_half");
  endtask

  task automatic test_saturation();
    do_single(0, 16'h8000, 8'h01, "sat_min");
    do_single(1, 16'h0600, 8'hFF, "six");
    do_single(2, 16'h7FFF, 8'hFF, "sat_max");
    do_single(3, 16'hFA00, 8'h01, "neg_six");
  endtask

  task automatic test_round_robin();
    logic [7:0] ys [4] = '{8'h80, 8'hBB, 8'hE1, 8'hF4};
    logic [3:0] exp_rdy;
    req_x     = {16'h0300, 16'h0200, 16'h0100, 16'h0000};
    req_valid = 4'b1111;
    for (int c = 0; c < 11; c++) begin
      @(negedge clk);
      exp_rdy = (c < 8) ? (4'b0001 << (c % 4)) : 4'b0000;
      total++;
      if (req_ready !== exp_rdy) begin
        bad++;
        $display("FAIL rr_grant c=%0d: got %b want %b", c, req_ready, exp_rdy);
      end
      total++;
      if (c >= 3) begin
        if ({resp_valid, resp_id, resp_y} !== {1'b1, 2'((c-3) % 4), ys[(c-3) % 4]}) begin
          bad++;
          $display("FAIL rr_resp c=%0d: got v=%b id=%0d y=%h want v=1 id=%0d y=%h",
                   c, resp_valid, resp_id, resp_y, (c-3) % 4, ys[(c-3) % 4]);
        end
      end else if (resp_valid !== 1'b0) begin
        bad++;
        $display("FAIL rr_fill c=%0d: got resp_valid=%b want 0", c, resp_valid);
      end
      @(posedge clk);
      #1;
      if (c == 7) req_valid = 4'b0000;
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] ys [4] = '{8'h45, 8'hBB, 8'h01, 8'h9F};
    logic [9:0] q[$];
    logic [9:0] exp_v;
    logic [9:0] prev_resp;
    logic       stalled_prev;
    logic [3:0] exp_rdy;
    int         exp_g;
    int         popped;
    exp_g        = 0;
    popped       = 0;
    stalled_prev = 1'b0;
    prev_resp    = '0;
    req_x        = {16'h0080, 16'h8000, 16'h0100, 16'hFF00};
    req_valid    = 4'b1111;
    for (int c = 0; c < 40; c++) begin
      resp_ready = !(c >= 5 && c < 9);
      @(negedge clk);
      if (stalled_prev) begin
        total++;
        if ({resp_valid, resp_id, resp_y} !== {1'b1, prev_resp}) begin
          bad++;
          $display("FAIL stall_hold c=%0d: got v=%b id/y=%h want v=1 id/y=%h",
                   c, resp_valid, {resp_id, resp_y}, prev_resp);
        end
      end
      if (resp_valid && !resp_ready) begin
        total++;
        if (req_ready !== 4'b0000) begin
          bad++;
          $display("FAIL stall_ready c=%0d: got %b want 0000", c, req_ready);
        end
      end else if (req_valid != 4'b0000) begin
        exp_rdy = 4'b0001 << exp_g;
        total++;
        if (req_ready !== exp_rdy) begin
          bad++;
          $display("FAIL b2b_order c=%0d: got %b want %b", c, req_ready, exp_rdy);
        end
      end
      if ((req_ready & req_valid) != 4'b0000) begin
        q.push_back({2'(exp_g), ys[exp_g]});
        exp_g = (exp_g + 1) % 4;
      end
      if (resp_valid && resp_ready) begin
        popped++;
        total++;
        if (q.size() == 0) begin
          bad++;
          $display("FAIL b2b_extra c=%0d: got id/y=%h want no response", c, {resp_id, resp_y});
        end else begin
          exp_v = q.pop_front();
          if ({resp_id, resp_y} !== exp_v) begin
            bad++;
            $display("FAIL b2b_data c=%0d: got id/y=%h want %h", c, {resp_id, resp_y}, exp_v);
          end
        end
      end
      stalled_prev = resp_valid && !resp_ready;
      prev_resp    = {resp_id, resp_y};
      @(posedge clk);
      #1;
      if (c == 11) req_valid = 4'b0000;
      if (c >= 11 && q.size() == 0 && !busy) break;
    end
    resp_ready = 1'b1;
    total++;
    if (popped != 8 || q.size() != 0) begin
      bad++;
      $display("FAIL b2b_count: got popped=%0d pending=%0d want popped=8 pending=0",
               popped, q.size());
    end
  endtask

  task automatic test_reset_mid();
    resp_ready = 1'b1;
    req_x      = {16'h0000, 16'h0200, 16'h0100, 16'h0000};
    req_valid  = 4'b0010;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if ({resp_valid, busy} !== 2'b11) begin
      bad++;
      $display("FAIL mid_inflight: got v=%b busy=%b want 1 1", resp_valid, busy);
    end
    req_valid = 4'b0000;
    rst       = 1'b1;
    #1;
    total++;
    if ({resp_valid, busy, resp_y} !== 10'h000) begin
      bad++;
      $display("FAIL mid_reset: got v=%b busy=%b y=%h want 0 0 00", resp_valid, busy, resp_y);
    end
    @(posedge clk);
    #1 rst = 1'b0;
    req_valid = 4'b1110;
    @(negedge clk);
    total++;
    if (req_ready !== 4'b0010) begin
      bad++;
      $display("FAIL ptr_reset: got %b want 0010", req_ready);
    end
    #1 req_valid = 4'b0100;
    #1;
    total++;
    if (req_ready !== 4'b0100) begin
      bad++;
      $display("FAIL post_reset_grant: got %b want 0100", req_ready);
    end
    @(posedge clk);
    #1 req_valid = 4'b0000;
    @(posedge clk);
    @(negedge clk);
    total++;
    if (resp_valid !== 1'b0) begin
      bad++;
      $display("FAIL post_reset_stale: got resp_valid=%b want 0", resp_valid);
    end
    @(posedge clk);
    @(negedge clk);
    total++;
    if ({resp_valid, resp_id, resp_y} !== {1'b1, 2'd2, 8'hE1}) begin
      bad++;
      $display("FAIL post_reset_resp: got v=%b id=%0d y=%h want v=1 id=2 y=e1",
               resp_valid, resp_id, resp_y);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_sign();
    test_saturation();
    test_round_robin();
    test_back_to_back();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
